// File: rtl/pcecd_cdb_assembler.sv
// pcecd_cdb_assembler
// Collects PC Engine CD command bytes (one per REQ/ACK handshake) into a packed
// CDB whose length is fixed by the opcode group. The complete CDB is then handed
// to the command executor over a valid/ready handshake. A partial CDB is dropped
// after TIMEOUT_CYCLES idle cycles, and i_abort discards any work in progress.
module pcecd_cdb_assembler #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter logic [3:0]  VENDOR_LEN     = 4'd10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_byte_ready,
    output logic        o_want_more,
    input  logic        i_abort,
    output logic        o_cdb_valid,
    input  logic        i_cdb_ready,
    output logic [95:0] o_cdb,
    output logic [3:0]  o_cdb_len,
    output logic        o_illegal,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t       state_q;
    logic [95:0]  cdb_q;
    logic [3:0]   cdb_len_q;
    logic [3:0]   len_q;
    logic [3:0]   cnt_q;
    logic [15:0]  idle_q;
    logic         want_more_q;
    logic         valid_q;
    logic         illegal_q;
    logic         timeout_q;
    logic         byte_ready_q;

    logic [3:0]   opc_len_d;
    logic         opc_illegal_d;
    logic [3:0]   cnt_d;
    logic [6:0]   wr_idx_d;

    assign cnt_d    = cnt_q + 4'd1;
    assign wr_idx_d = {cnt_q, 3'b000};

    // Opcode group decode: CDB length and reserved-group flag from bits [7:5].
    always_comb begin
        opc_len_d     = 4'd1;
        opc_illegal_d = 1'b0;
        unique case (i_byte[7:5])
            3'b000:         opc_len_d = 4'd6;
            3'b001, 3'b010: opc_len_d = 4'd10;
            3'b101:         opc_len_d = 4'd12;
            3'b110, 3'b111: opc_len_d = VENDOR_LEN;
            default: begin
                opc_len_d     = 4'd1;
                opc_illegal_d = 1'b1;
            end
        endcase
    end

    // Assembler FSM: every output is a register updated here.
    // Abort shares the reset path and therefore wins over bytes, ready and timeout.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_abort) begin
            state_q      <= S_IDLE;
            cdb_q        <= '0;
            cdb_len_q    <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            idle_q       <= '0;
            want_more_q  <= 1'b0;
            valid_q      <= 1'b0;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
            byte_ready_q <= 1'b1;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (i_byte_valid) begin
                        cdb_q  <= {88'b0, i_byte};
                        cnt_q  <= 4'd1;
                        idle_q <= '0;
                        len_q  <= opc_len_d;
                        if (opc_illegal_d) begin
                            illegal_q    <= 1'b1;
                            valid_q      <= 1'b1;
                            cdb_len_q    <= 4'd1;
                            byte_ready_q <= 1'b0;
                            state_q      <= S_HOLD;
                        end else begin
                            want_more_q <= 1'b1;
                            cdb_len_q   <= '0;
                            state_q     <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (i_byte_valid) begin
                        cdb_q[wr_idx_d +: 8] <= i_byte;
                        cnt_q                <= cnt_d;
                        idle_q               <= '0;
                        // The 12-byte cap keeps a mis-set VENDOR_LEN from overrunning o_cdb.
                        if (cnt_d == len_q || cnt_d == 4'd12) begin
                            want_more_q  <= 1'b0;
                            cdb_len_q    <= cnt_d;
                            valid_q      <= 1'b1;
                            byte_ready_q <= 1'b0;
                            state_q      <= S_HOLD;
                        end
                    end else if (idle_q == TIMEOUT_CYCLES - 16'd1) begin
                        timeout_q   <= 1'b1;
                        want_more_q <= 1'b0;
                        cdb_q       <= '0;
                        cnt_q       <= '0;
                        idle_q      <= '0;
                        state_q     <= S_IDLE;
                    end else begin
                        idle_q <= idle_q + 16'd1;
                    end
                end
                S_HOLD: begin
                    if (i_cdb_ready) begin
                        valid_q      <= 1'b0;
                        illegal_q    <= 1'b0;
                        cnt_q        <= '0;
                        byte_ready_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    byte_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_byte_ready = byte_ready_q;
    assign o_want_more  = want_more_q;
    assign o_cdb_valid  = valid_q;
    assign o_cdb        = cdb_q;
    assign o_cdb_len    = cdb_len_q;
    assign o_illegal    = illegal_q;
    assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_pcecd_cdb_assembler.sv
// Testbench for pcecd_cdb_assembler: directed scenarios followed by a random
// phase. Every cycle is compared against a queue-based reference model.
module tb_pcecd_cdb_assembler;

    localparam logic [15:0] TO   = 16'd8;
    localparam logic [3:0]  VEND = 4'd10;
    localparam int M_IDLE = 0, M_COLLECT = 1, M_HOLD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic        byte_ready;
    logic        want_more;
    logic        abort_in;
    logic        cdb_valid;
    logic        cdb_ready;
    logic [95:0] cdb;
    logic [3:0]  cdb_len;
    logic        illegal;
    logic        timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    int         m_mode;
    logic [7:0] m_bytes[$];
    int         m_need;
    int         m_quiet;
    int         m_outlen;
    bit         m_valid, m_illegal, m_want, m_timeout;
    int         n_timeout_pulses = 0;

    pcecd_cdb_assembler #(.TIMEOUT_CYCLES(TO), .VENDOR_LEN(VEND)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_byte_valid(byte_valid), .i_byte(byte_in),
        .o_byte_ready(byte_ready), .o_want_more(want_more), .i_abort(abort_in),
        .o_cdb_valid(cdb_valid), .i_cdb_ready(cdb_ready), .o_cdb(cdb),
        .o_cdb_len(cdb_len), .o_illegal(illegal), .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    // CDB length by opcode range; 0 marks the reserved range 0x60..0x9F.
    function automatic int spec_len(input logic [7:0] op);
        if (op >= 8'hC0) return int'(VEND);
        if (op >= 8'hA0) return 12;
        if (op >= 8'h60) return 0;
        if (op >= 8'h20) return 10;
        return 6;
    endfunction

    function automatic logic [95:0] packed_cdb();
        logic [95:0] r = '0;
        foreach (m_bytes[i]) r[8*i +: 8] = m_bytes[i];
        return r;
    endfunction

    task automatic model_clear();
        m_mode = M_IDLE; m_bytes.delete(); m_need = 0; m_quiet = 0; m_outlen = 0;
        m_valid = 0; m_illegal = 0; m_want = 0; m_timeout = 0;
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_edge();
        m_timeout = 0;
        if (!rst_n || abort_in) begin
            model_clear();
            return;
        end
        case (m_mode)
            M_IDLE: if (byte_valid) begin
                m_bytes.delete();
                m_bytes.push_back(byte_in);
                m_need  = spec_len(byte_in);
                m_quiet = 0;
                if (m_need == 0) begin
                    m_illegal = 1; m_valid = 1; m_outlen = 1; m_mode = M_HOLD;
                end else begin
                    m_want = 1; m_outlen = 0; m_mode = M_COLLECT;
                end
            end
            M_COLLECT: if (byte_valid) begin
                m_bytes.push_back(byte_in);
                m_quiet = 0;
                if (m_bytes.size() == m_need) begin
                    m_want = 0; m_outlen = m_need; m_valid = 1; m_mode = M_HOLD;
                end
            end else begin
                m_quiet++;
                if (m_quiet == int'(TO)) begin
                    m_timeout = 1; m_want = 0; m_bytes.delete(); m_quiet = 0; m_mode = M_IDLE;
                end
            end
            default: if (cdb_ready) begin
                m_valid = 0; m_illegal = 0; m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("cdb",        cdb,                 packed_cdb());
        chk("cdb_len",    96'(cdb_len),        96'(m_outlen));
        chk("cdb_valid",  96'(cdb_valid),      96'(m_valid));
        chk("illegal",    96'(illegal),        96'(m_illegal));
        chk("want_more",  96'(want_more),      96'(m_want));
        chk("byte_ready", 96'(byte_ready),     96'(m_mode != M_HOLD));
        chk("timeout",    96'(timeout),        96'(m_timeout));
    endtask

    // One clock: apply inputs, step model, sample 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [7:0] b, input logic rdy, input logic ab);
        byte_valid = v; byte_in = b; cdb_ready = rdy; abort_in = ab;
        model_edge();
        @(posedge clk);
        #1;
        if (timeout === 1'b1) n_timeout_pulses++;
        check_all();
    endtask

    task automatic idle_cycles(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, rdy, 1'b0);
    endtask

    logic [7:0] read6[6]  = '{8'h08, 8'h00, 8'h12, 8'h34, 8'h04, 8'h00};
    logic [7:0] vend10[10] = '{8'hD8, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00};

    initial begin
        model_clear();
        rst_n = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; cdb_ready = 1'b0; abort_in = 1'b0;

        // Reset state
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h08, 1'b0, 1'b0);
        chk("reset_ready", 96'(byte_ready), 96'd1);
        rst_n = 1'b1;

        // READ(6) back-to-back with executor ready
        foreach (read6[i]) cyc(1'b1, read6[i], 1'b1, 1'b0);
        chk("read6_cdb", cdb, {48'b0, 48'h0004_3412_0008});
        chk("read6_len", 96'(cdb_len), 96'd6);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("read6_valid_1cyc", 96'(cdb_valid), 96'd0);

        // Vendor D8 with 3-cycle gaps
        foreach (vend10[i]) begin
            cyc(1'b1, vend10[i], 1'b0, 1'b0);
            if (i < 9) begin
                idle_cycles(3, 1'b0);
                chk("vend_want_more", 96'(want_more), 96'd1);
            end
        end
        chk("vend_len", 96'(cdb_len), 96'd10);
        chk("vend_byte8", 96'(cdb[71:64]), 96'h80);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Illegal opcode
        cyc(1'b1, 8'h60, 1'b0, 1'b0);
        chk("illegal_flag", 96'(illegal), 96'd1);
        idle_cycles(2, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Backpressure with a byte offered during HOLD
        foreach (read6[i]) cyc(1'b1, read6[i], 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'h00, 1'b0, 1'b0);
        chk("bp_cdb_kept", cdb, {48'b0, 48'h0004_3412_0008});
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'hA8, 1'b0, 1'b0);
        chk("bp_next_opcode", 96'(want_more), 96'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Timeout after 28 00
        n_timeout_pulses = 0;
        cyc(1'b1, 8'h28, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        idle_cycles(12, 1'b0);
        chk("timeout_once", 96'(n_timeout_pulses), 96'd1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'h00, 1'b0, 1'b0);
        chk("after_to_len", 96'(cdb_len), 96'd6);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Abort with 4th byte of a 10-byte CDB, then abort during HOLD
        n_timeout_pulses = 0;
        for (int i = 0; i < 3; i++) cyc(1'b1, vend10[i], 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b1);
        chk("abort_cdb", cdb, 96'd0);
        cyc(1'b1, 8'h70, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("abort_hold_valid", 96'(cdb_valid), 96'd0);
        idle_cycles(10, 1'b0);
        chk("abort_no_timeout", 96'(n_timeout_pulses), 96'd0);

        // Reset mid-COLLECT
        cyc(1'b1, 8'hC5, 1'b0, 1'b0);
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk("rst_mid_want", 96'(want_more), 96'd0);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            logic       v, r, a;
            logic [7:0] b;
            v = ($urandom_range(0, 3) != 0);
            b = 8'($urandom);
            r = ($urandom_range(0, 2) == 0);
            a = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 199) == 0) idle_cycles(int'(TO) + 2, 1'b0);
            cyc(v, b, r, a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pcecd_cdb_assembler.md
# pcecd_cdb_assembler

Collects the command bytes that the PC Engine CD drive front end latches during PHASE_COMMAND, one byte per REQ/ACK handshake. It determines the command descriptor block (CDB) length from the opcode group and assembles the bytes into a packed CDB. It then presents the complete CDB to the command executor through a valid/ready handshake. It sits directly downstream of the $1800–$1804 register/phase block and replaces that block's unbounded 256-entry command buffer with a bounded, length-aware assembler.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16'd50000: maximum idle cycles between bytes of one CDB before the command is abandoned.
- VENDOR_LEN, 4'd10: CDB length used for vendor opcodes 0xC0–0xFF (PCE commands D8/D9/DA/DD/DE).

Ports:
- i_clk, in, 1: sole clock.
- i_rst_n, in, 1: reset, synchronous, active-low.
- i_byte_valid, in, 1: command byte strobe from the phase block (REQ && ACK in PHASE_COMMAND).
- i_byte, in, 8: command byte (r_CDCommand value).
- o_byte_ready, out, 1: the assembler can take a byte this cycle.
- o_want_more, out, 1: CDB incomplete; the phase block must re-assert REQ.
- i_abort, in, 1: bus reset / virtual reset; discards any partial or pending CDB.
- o_cdb_valid, out, 1: complete CDB available.
- i_cdb_ready, in, 1: executor accepts the CDB.
- o_cdb, out, 96: packed CDB. Byte n is at [8n+7:8n]; bytes at or beyond the length read 0.
- o_cdb_len, out, 4: number of bytes in the CDB (1, 6, 10, 12).
- o_illegal, out, 1: qualifies o_cdb_valid; the opcode is in the reserved group.
- o_timeout, out, 1: one-cycle pulse when a partial CDB is dropped by timeout.

## Operation
- States: IDLE, COLLECT, HOLD.
- Reset (i_rst_n=0 at posedge):
  - state=IDLE.
  - o_cdb=0, o_cdb_len=0, byte count=0, idle counter=0.
  - o_cdb_valid=0, o_illegal=0, o_timeout=0, o_want_more=0.
  - o_byte_ready=1 from the first cycle after reset.
- o_byte_ready=1 in IDLE and COLLECT; 0 in HOLD. Bytes offered while not ready are ignored, not queued.
- IDLE, byte accepted:
  - o_cdb is cleared.
  - The byte is stored at byte 0 and count=1.
  - Length by opcode[7:5]:
    - 000 → 6.
    - 001, 010 → 10.
    - 101 → 12.
    - 110, 111 → VENDOR_LEN.
    - 011, 100 → illegal, length 1.
  - If illegal: go to HOLD with o_illegal=1 and o_cdb_len=1. Otherwise go to COLLECT with o_want_more=1.
- COLLECT, byte accepted:
  - The byte is stored at index count, count increments, and the idle counter clears.
  - When the new count equals the length: o_want_more=0, o_cdb_len=length, go to HOLD.
- COLLECT, no byte:
  - The idle counter increments.
  - When it reaches TIMEOUT_CYCLES-1: o_timeout pulses, o_want_more=0, o_cdb=0, go to IDLE.
- HOLD:
  - o_cdb_valid=1; o_cdb, o_cdb_len and o_illegal stay stable.
  - On i_cdb_ready=1: o_cdb_valid=0, o_illegal=0, go to IDLE.
- i_abort (synchronous, any state): go to IDLE and clear everything as in reset.
  - It takes priority over a simultaneous byte, over i_cdb_ready, and over a timeout.
  - No o_timeout pulse is produced.
- Count is 4 bits and never exceeds 12. Length is held in a register from the opcode cycle, so it does not depend on later bytes.

## Timing
- All outputs are registered. Changes are visible the cycle after the causing posedge.
- The last CDB byte accepted at edge k gives o_cdb_valid=1 after edge k. An illegal opcode at edge k behaves the same way.
- The earliest next opcode acceptance is the edge after the accepting i_cdb_ready edge. There is no same-cycle IDLE re-entry while in HOLD.
- o_want_more rises after the opcode edge and falls after the final-byte edge.
- Timeout: with the last byte at edge k, o_timeout is high for exactly the cycle after edge k+TIMEOUT_CYCLES.
- Throughput: one byte per cycle is sustained in COLLECT.

## Test plan
- READ(6): bytes 08 00 12 34 04 00 on consecutive cycles, i_cdb_ready=1 → o_cdb_valid for 1 cycle after byte 6; o_cdb_len=6; o_cdb[47:0]=48'h0004_3412_0008; upper bits 0.
- Vendor D8: bytes D8 00 00 02 00 00 00 00 80 00 with gaps of 3 cycles → o_want_more=1 throughout; o_cdb_len=10; o_cdb[7:0]=D8; o_cdb[71:64]=80.
- Illegal 0x60 → o_cdb_valid=1, o_illegal=1, o_cdb_len=1 the cycle after acceptance; o_want_more never set.
- Backpressure: hold i_cdb_ready=0 for 20 cycles after a 6-byte CDB while offering byte 00 → o_byte_ready=0, o_cdb unchanged, extra byte ignored; release → IDLE; the next opcode is accepted normally.
- Timeout (TIMEOUT_CYCLES=8): send 28 00 then stop → o_timeout pulses once, state IDLE; a following 00 byte starts a new 6-byte CDB.
- Abort: i_abort together with the 4th byte of a 10-byte CDB, and separately during HOLD → all outputs return to reset values the next cycle; no o_timeout; i_rst_n=0 mid-COLLECT gives the same result.
